// File: rtl/mem_wb_stage.sv
// -----------------------------------------------------------------------------
// mem_wb_stage
//   Memory-access / writeback stage of the RV32I core. One retiring instruction
//   is accepted per valid/ready handshake. ALU results are forwarded to the
//   register file one cycle later. Loads issue a word-aligned request on a
//   simple req/ack data bus. The returned word is reduced to a byte, halfword or
//   word, then sign- or zero-extended and written one cycle after the ack.
//
// Ports
//   clk, reset_n           clock, asynchronous active-low reset
//   mem_valid_in           instruction offered by MEM stage
//   mem_ready_out          stage idle and able to accept (decoded from state)
//   mem_reg_enable_in      instruction writes rd
//   mem_rd_addr_in         destination register
//   mem_alu_result_in      ALU result / load byte address
//   mem_is_load_in         instruction is a load
//   mem_funct3_in          load width/sign selector
//   dbus_req_out           load request, held until ack/err/timeout
//   dbus_addr_out          word-aligned load address
//   dbus_ack_in            read data valid
//   dbus_err_in            bus error
//   dbus_rdata_in          read word
//   wb_reg_enable_out      register file write strobe
//   wb_rd_addr_out         register file write address
//   wb_rd_data_out         register file write data
//   load_fault_out         one-cycle pulse on a rejected or failed load
// -----------------------------------------------------------------------------
module mem_wb_stage #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_valid_in,
  output logic        mem_ready_out,
  input  logic        mem_reg_enable_in,
  input  logic [4:0]  mem_rd_addr_in,
  input  logic [31:0] mem_alu_result_in,
  input  logic        mem_is_load_in,
  input  logic [2:0]  mem_funct3_in,
  output logic        dbus_req_out,
  output logic [31:0] dbus_addr_out,
  input  logic        dbus_ack_in,
  input  logic        dbus_err_in,
  input  logic [31:0] dbus_rdata_in,
  output logic        wb_reg_enable_out,
  output logic [4:0]  wb_rd_addr_out,
  output logic [31:0] wb_rd_data_out,
  output logic        load_fault_out
);

  localparam logic STATE_IDLE      = 1'b0;
  localparam logic STATE_LOAD_WAIT = 1'b1;

  // Counter value of the last LOAD_WAIT cycle that may still see a response.
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic        state_q,    state_d;
  logic [15:0] cnt_q,      cnt_d;
  logic        req_q,      req_d;
  logic [31:0] addr_q,     addr_d;
  logic [4:0]  ld_rd_q,    ld_rd_d;
  logic [2:0]  ld_f3_q,    ld_f3_d;
  logic [1:0]  ld_off_q,   ld_off_d;
  logic        ld_en_q,    ld_en_d;
  logic        wb_en_q,    wb_en_d;
  logic [4:0]  wb_addr_q,  wb_addr_d;
  logic [31:0] wb_data_q,  wb_data_d;
  logic        fault_q,    fault_d;

  logic        transfer;
  logic        load_bad;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_data;

  assign mem_ready_out = (state_q == STATE_IDLE);
  assign transfer      = mem_valid_in && (state_q == STATE_IDLE);

  // Illegal width encodings and misaligned halfword/word accesses are rejected
  // before any bus activity.
  always_comb begin
    load_bad = 1'b0;
    case (mem_funct3_in)
      3'b000, 3'b100: load_bad = 1'b0;
      3'b001, 3'b101: load_bad = mem_alu_result_in[0];
      3'b010:         load_bad = (mem_alu_result_in[1:0] != 2'b00);
      default:        load_bad = 1'b1;
    endcase
  end

  // Lane extraction from the returned word using the latched byte offset.
  always_comb begin
    sel_byte = dbus_rdata_in[7:0];
    case (ld_off_q)
      2'd0: sel_byte = dbus_rdata_in[7:0];
      2'd1: sel_byte = dbus_rdata_in[15:8];
      2'd2: sel_byte = dbus_rdata_in[23:16];
      2'd3: sel_byte = dbus_rdata_in[31:24];
      default: sel_byte = dbus_rdata_in[7:0];
    endcase
    sel_half = ld_off_q[1] ? dbus_rdata_in[31:16] : dbus_rdata_in[15:0];
    case (ld_f3_q)
      3'b000:  load_data = {{24{sel_byte[7]}}, sel_byte};
      3'b100:  load_data = {24'd0, sel_byte};
      3'b001:  load_data = {{16{sel_half[15]}}, sel_half};
      3'b101:  load_data = {16'd0, sel_half};
      default: load_data = dbus_rdata_in;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    ld_rd_d   = ld_rd_q;
    ld_f3_d   = ld_f3_q;
    ld_off_d  = ld_off_q;
    ld_en_d   = ld_en_q;
    // Writeback outputs return to all-zero on every non-write cycle so the
    // register file never forwards on a stale address.
    wb_en_d   = 1'b0;
    wb_addr_d = 5'd0;
    wb_data_d = 32'd0;
    fault_d   = 1'b0;

    if (state_q == STATE_IDLE) begin
      if (transfer) begin
        if (!mem_is_load_in) begin
          if (mem_reg_enable_in && (mem_rd_addr_in != 5'd0)) begin
            wb_en_d   = 1'b1;
            wb_addr_d = mem_rd_addr_in;
            wb_data_d = mem_alu_result_in;
          end
        end else if (load_bad) begin
          fault_d = 1'b1;
        end else begin
          state_d  = STATE_LOAD_WAIT;
          cnt_d    = 16'd0;
          addr_d   = {mem_alu_result_in[31:2], 2'b00};
          ld_rd_d  = mem_rd_addr_in;
          ld_f3_d  = mem_funct3_in;
          ld_off_d = mem_alu_result_in[1:0];
          ld_en_d  = mem_reg_enable_in;
        end
      end
    end else begin
      if (dbus_err_in) begin
        state_d = STATE_IDLE;
        fault_d = 1'b1;
      end else if (dbus_ack_in) begin
        state_d = STATE_IDLE;
        if (ld_en_q && (ld_rd_q != 5'd0)) begin
          wb_en_d   = 1'b1;
          wb_addr_d = ld_rd_q;
          wb_data_d = load_data;
        end
      end else if (cnt_q == TIMEOUT_LAST) begin
        state_d = STATE_IDLE;
        fault_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end

    req_d = (state_d == STATE_LOAD_WAIT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= STATE_IDLE;
      cnt_q     <= 16'd0;
      req_q     <= 1'b0;
      addr_q    <= 32'd0;
      ld_rd_q   <= 5'd0;
      ld_f3_q   <= 3'd0;
      ld_off_q  <= 2'd0;
      ld_en_q   <= 1'b0;
      wb_en_q   <= 1'b0;
      wb_addr_q <= 5'd0;
      wb_data_q <= 32'd0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      ld_rd_q   <= ld_rd_d;
      ld_f3_q   <= ld_f3_d;
      ld_off_q  <= ld_off_d;
      ld_en_q   <= ld_en_d;
      wb_en_q   <= wb_en_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      fault_q   <= fault_d;
    end
  end

  assign dbus_req_out      = req_q;
  assign dbus_addr_out     = addr_q;
  assign wb_reg_enable_out = wb_en_q;
  assign wb_rd_addr_out    = wb_addr_q;
  assign wb_rd_data_out    = wb_data_q;
  assign load_fault_out    = fault_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_wb_stage
//   Directed self-checking bench for mem_wb_stage (TIMEOUT_CYCLES = 4).
//   Inputs are driven and outputs sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mem_valid_in;
  logic        mem_ready_out;
  logic        mem_reg_enable_in;
  logic [4:0]  mem_rd_addr_in;
  logic [31:0] mem_alu_result_in;
  logic        mem_is_load_in;
  logic [2:0]  mem_funct3_in;
  logic        dbus_req_out;
  logic [31:0] dbus_addr_out;
  logic        dbus_ack_in;
  logic        dbus_err_in;
  logic [31:0] dbus_rdata_in;
  logic        wb_reg_enable_out;
  logic [4:0]  wb_rd_addr_out;
  logic [31:0] wb_rd_data_out;
  logic        load_fault_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_wb_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .mem_valid_in      (mem_valid_in),
    .mem_ready_out     (mem_ready_out),
    .mem_reg_enable_in (mem_reg_enable_in),
    .mem_rd_addr_in    (mem_rd_addr_in),
    .mem_alu_result_in (mem_alu_result_in),
    .mem_is_load_in    (mem_is_load_in),
    .mem_funct3_in     (mem_funct3_in),
    .dbus_req_out      (dbus_req_out),
    .dbus_addr_out     (dbus_addr_out),
    .dbus_ack_in       (dbus_ack_in),
    .dbus_err_in       (dbus_err_in),
    .dbus_rdata_in     (dbus_rdata_in),
    .wb_reg_enable_out (wb_reg_enable_out),
    .wb_rd_addr_out    (wb_rd_addr_out),
    .wb_rd_data_out    (wb_rd_data_out),
    .load_fault_out    (load_fault_out)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end else begin
      $display("ok   %s = %08h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic is_load, input logic [2:0] f3, input logic en,
                       input logic [4:0] rd, input logic [31:0] alu);
    mem_valid_in      = 1'b1;
    mem_is_load_in    = is_load;
    mem_funct3_in     = f3;
    mem_reg_enable_in = en;
    mem_rd_addr_in    = rd;
    mem_alu_result_in = alu;
  endtask

  task automatic drop();
    mem_valid_in      = 1'b0;
    mem_is_load_in    = 1'b0;
    mem_funct3_in     = 3'd0;
    mem_reg_enable_in = 1'b0;
    mem_rd_addr_in    = 5'd0;
    mem_alu_result_in = 32'd0;
  endtask

  task automatic wb_none(input string tag);
    check_eq({tag, "_wen"},   32'(wb_reg_enable_out), 32'd0);
    check_eq({tag, "_waddr"}, 32'(wb_rd_addr_out),    32'd0);
    check_eq({tag, "_wdata"}, wb_rd_data_out,         32'd0);
  endtask

  task automatic wb_write(input string tag, input logic [4:0] rd, input logic [31:0] data);
    check_eq({tag, "_wen"},   32'(wb_reg_enable_out), 32'd1);
    check_eq({tag, "_waddr"}, 32'(wb_rd_addr_out),    32'(rd));
    check_eq({tag, "_wdata"}, wb_rd_data_out,         data);
  endtask

  // Full load transaction: ack arrives after 'waits' request cycles without it.
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [4:0] rd, input int waits,
                         input logic [31:0] rdata, input logic [31:0] exp_data);
    offer(1'b1, f3, 1'b1, rd, addr);
    check_eq({tag, "_rdy_issue"}, 32'(mem_ready_out), 32'd1);
    step();
    drop();
    check_eq({tag, "_req"},   32'(dbus_req_out), 32'd1);
    check_eq({tag, "_daddr"}, dbus_addr_out, {addr[31:2], 2'b00});
    check_eq({tag, "_rdy_wait"}, 32'(mem_ready_out), 32'd0);
    for (int i = 0; i < waits; i++) begin
      step();
      check_eq({tag, "_req_hold"}, 32'(dbus_req_out), 32'd1);
    end
    dbus_ack_in   = 1'b1;
    dbus_rdata_in = rdata;
    step();
    dbus_ack_in   = 1'b0;
    dbus_rdata_in = 32'd0;
    check_eq({tag, "_req_drop"}, 32'(dbus_req_out), 32'd0);
    check_eq({tag, "_rdy_done"}, 32'(mem_ready_out), 32'd1);
    if (rd != 5'd0) wb_write(tag, rd, exp_data);
    else            wb_none(tag);
    step();
    wb_none({tag, "_after"});
  endtask

  // Rejected load: no request, single-cycle fault, no write.
  task automatic bad_load(input string tag, input logic [2:0] f3, input logic [31:0] addr);
    offer(1'b1, f3, 1'b1, 5'd9, addr);
    step();
    drop();
    check_eq({tag, "_req"},   32'(dbus_req_out),   32'd0);
    check_eq({tag, "_fault"}, 32'(load_fault_out), 32'd1);
    check_eq({tag, "_rdy"},   32'(mem_ready_out),  32'd1);
    wb_none(tag);
    step();
    check_eq({tag, "_fault_end"}, 32'(load_fault_out), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n       = 1'b0;
    dbus_ack_in   = 1'b0;
    dbus_err_in   = 1'b0;
    dbus_rdata_in = 32'd0;
    drop();
    step();
    step();
    check_eq("rst_rdy",   32'(mem_ready_out),  32'd1);
    check_eq("rst_req",   32'(dbus_req_out),   32'd0);
    check_eq("rst_daddr", dbus_addr_out,       32'd0);
    check_eq("rst_fault", 32'(load_fault_out), 32'd0);
    wb_none("rst");
    reset_n = 1'b1;
    step();

    // ALU stream, back to back
    offer(1'b0, 3'd0, 1'b1, 5'd5, 32'h0000_1234);
    step();
    wb_write("alu_x5", 5'd5, 32'h0000_1234);
    offer(1'b0, 3'd0, 1'b1, 5'd0, 32'h0000_FFFF);
    step();
    wb_none("alu_x0");
    offer(1'b0, 3'd0, 1'b0, 5'd7, 32'h0000_AAAA);
    step();
    drop();
    wb_none("alu_noen");
    step();
    wb_none("alu_idle");

    // Load extraction with three no-ack wait cycles
    do_load("lb3",  3'b000, 32'h0000_1003, 5'd1, 3, 32'h80FF_7F01, 32'hFFFF_FF80);
    do_load("lbu1", 3'b100, 32'h0000_2001, 5'd2, 3, 32'h80FF_7F01, 32'h0000_007F);
    do_load("lh2",  3'b001, 32'h0000_3002, 5'd3, 3, 32'h80FF_7F01, 32'hFFFF_80FF);
    do_load("lhu0", 3'b101, 32'h0000_4000, 5'd4, 3, 32'h80FF_7F01, 32'h0000_7F01);
    do_load("lw",   3'b010, 32'h0000_5004, 5'd6, 3, 32'h80FF_7F01, 32'h80FF_7F01);
    do_load("lb1",  3'b000, 32'h0000_6001, 5'd8, 0, 32'h1234_8056, 32'hFFFF_FF80);
    do_load("lw_x0", 3'b010, 32'h0000_7000, 5'd0, 1, 32'hDEAD_BEEF, 32'd0);

    // Rejected loads
    bad_load("lw_mis", 3'b010, 32'h0000_1002);
    bad_load("f3_011", 3'b011, 32'h0000_1000);
    bad_load("lh_odd", 3'b001, 32'h0000_1001);

    // Ack and err together in the first request cycle
    offer(1'b1, 3'b000, 1'b1, 5'd11, 32'h0000_0010);
    step();
    drop();
    dbus_ack_in = 1'b1;
    dbus_err_in = 1'b1;
    dbus_rdata_in = 32'h0000_00FF;
    step();
    dbus_ack_in = 1'b0;
    dbus_err_in = 1'b0;
    check_eq("err_fault", 32'(load_fault_out), 32'd1);
    check_eq("err_req",   32'(dbus_req_out),   32'd0);
    check_eq("err_rdy",   32'(mem_ready_out),  32'd1);
    wb_none("err");
    step();
    check_eq("err_fault_end", 32'(load_fault_out), 32'd0);

    // Timeout with no response: request high exactly 4 cycles
    offer(1'b1, 3'b010, 1'b1, 5'd12, 32'h0000_0020);
    step();
    drop();
    for (int i = 0; i < 4; i++) begin
      check_eq("to_req",   32'(dbus_req_out),   32'd1);
      check_eq("to_nofault", 32'(load_fault_out), 32'd0);
      step();
    end
    check_eq("to_req_drop", 32'(dbus_req_out),   32'd0);
    check_eq("to_fault",    32'(load_fault_out), 32'd1);
    check_eq("to_rdy",      32'(mem_ready_out),  32'd1);
    wb_none("to");
    step();
    check_eq("to_fault_end", 32'(load_fault_out), 32'd0);

    // Reset in the middle of a load
    offer(1'b1, 3'b010, 1'b1, 5'd13, 32'h0000_0040);
    step();
    drop();
    step();
    check_eq("mr_req_before", 32'(dbus_req_out), 32'd1);
    reset_n = 1'b0;
    #1;
    check_eq("mr_req",   32'(dbus_req_out),   32'd0);
    check_eq("mr_daddr", dbus_addr_out,       32'd0);
    check_eq("mr_rdy",   32'(mem_ready_out),  32'd1);
    check_eq("mr_fault", 32'(load_fault_out), 32'd0);
    wb_none("mr");
    step();
    reset_n = 1'b1;
    dbus_ack_in = 1'b1;
    dbus_rdata_in = 32'h5555_5555;
    step();
    step();
    dbus_ack_in = 1'b0;
    dbus_rdata_in = 32'd0;
    wb_none("mr_late_ack");
    check_eq("mr_late_req", 32'(dbus_req_out), 32'd0);

    // Alternating immediate-ack loads and ALU ops
    for (int k = 0; k < 4; k++) begin
      offer(1'b1, 3'b010, 1'b1, 5'(10 + k), 32'(k * 256));
      check_eq("alt_rdy_issue", 32'(mem_ready_out), 32'd1);
      step();
      drop();
      check_eq("alt_req",      32'(dbus_req_out),  32'd1);
      check_eq("alt_rdy_low",  32'(mem_ready_out), 32'd0);
      dbus_ack_in   = 1'b1;
      dbus_rdata_in = 32'hA000_0000 + 32'(k);
      step();
      dbus_ack_in   = 1'b0;
      dbus_rdata_in = 32'd0;
      check_eq("alt_rdy_back", 32'(mem_ready_out), 32'd1);
      wb_write("alt_ld", 5'(10 + k), 32'hA000_0000 + 32'(k));
      offer(1'b0, 3'd0, 1'b1, 5'(20 + k), 32'h0000_0500 + 32'(k));
      step();
      drop();
      check_eq("alt_rdy_alu", 32'(mem_ready_out), 32'd1);
      wb_write("alt_alu", 5'(20 + k), 32'h0000_0500 + 32'(k));
    end
    step();
    wb_none("alt_end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory-access/writeback stage of the RV32I core, directly upstream of the register file. Accepts one retiring instruction per handshake from the MEM side, performs loads over a simple request/acknowledge data bus with byte/halfword extraction and sign extension, and drives the register file write port (enable, rd address, rd data) for exactly one cycle per completed write. Non-load results pass through with one cycle of latency.

## Interface
- TIMEOUT_CYCLES, 255: maximum number of LOAD_WAIT cycles without ack or err before a load is abandoned; range 1..65535.

- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- mem_valid_in  in  1  instruction offered by MEM stage
- mem_ready_out  out  1  stage accepts offer this cycle (transfer = valid & ready)
- mem_reg_enable_in  in  1  instruction writes rd
- mem_rd_addr_in  in  5  destination register
- mem_alu_result_in  in  32  ALU result; load byte address when mem_is_load_in=1
- mem_is_load_in  in  1  instruction is a load
- mem_funct3_in  in  3  load width: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- dbus_req_out  out  1  load request, held until ack/err/timeout
- dbus_addr_out  out  32  word-aligned address ({addr[31:2],2'b00})
- dbus_ack_in  in  1  read data valid this cycle
- dbus_err_in  in  1  bus error this cycle
- dbus_rdata_in  in  32  read word
- wb_reg_enable_out  out  1  register write strobe (to register file write enable)
- wb_rd_addr_out  out  5  register write address
- wb_rd_data_out  out  32  register write data
- load_fault_out  out  1  one-cycle pulse: misaligned, illegal funct3, bus error or timeout

## Operation
- States: IDLE, LOAD_WAIT. mem_ready_out = (state == IDLE), decoded from state register only.
- IDLE, transfer, non-load: next cycle drive wb_* with enable=mem_reg_enable_in & (rd!=0), addr=rd, data=alu_result; state stays IDLE.
- IDLE, transfer, load: check alignment/funct3. LH/LHU with addr[0]=1, LW with addr[1:0]!=0, or funct3 in {011,110,111} -> no bus request, load_fault_out pulses next cycle, no register write, stay IDLE. Otherwise latch rd, funct3, addr[1:0], enable; assert dbus_req_out next cycle; go LOAD_WAIT; clear timeout counter.
- LOAD_WAIT: dbus_req_out=1, dbus_addr_out stable. On err (err wins over simultaneous ack): drop req, pulse fault, no write, go IDLE. On ack: drop req, write extracted data next cycle, go IDLE. Else counter increments; when counter reaches TIMEOUT_CYCLES-1 with no response: drop req, pulse fault, go IDLE.
- Extraction, off=addr[1:0]: LB/LBU byte rdata[8*off+7:8*off], LH/LHU halfword rdata[16*addr[1]+15:16*addr[1]]; LB/LH sign-extend, LBU/LHU zero-extend; LW full word.
- Non-write cycles: wb_reg_enable_out=0 AND wb_rd_addr_out=0 AND wb_rd_data_out=0. Mandatory: the register file forwards rd_data on any rs/rd address match regardless of enable, so a stale nonzero address would corrupt operand reads.
- Loads to rd=0 still perform the bus access; the write is suppressed per the rule above.
- dbus_ack_in/dbus_err_in in IDLE are ignored.

## Timing
- Reset (asynchronous assert, synchronous deassert externally): state IDLE, counter 0, all outputs 0 except mem_ready_out=1. Reset during LOAD_WAIT drops dbus_req_out immediately; a later ack is ignored.
- Non-load accepted in cycle N -> wb_* valid in cycle N+1 only.
- Load accepted in N -> dbus_req_out high from N+1; ack in cycle M (M >= N+1) -> dbus_req_out low in M+1, write in M+1, mem_ready_out high in M+1. Minimum load latency 2 cycles.
- Timeout: req high N+1..N+TIMEOUT_CYCLES, fault pulse and req low in N+TIMEOUT_CYCLES+1.
- Fault pulses are exactly one cycle wide; all wb_* and dbus_* outputs registered.
- Back-to-back non-loads: one per cycle, no bubbles.

## Test plan
- Reset mid-load: assert reset_n=0 during LOAD_WAIT -> req drops same cycle, all outputs 0, ready=1; ack afterward produces no write.
- ALU stream: rd=5 data 0x1234, rd=0 data 0xFFFF, rd=7 enable=0 on consecutive cycles -> write x5=0x1234 in N+1; N+2 and N+3 show enable=0, addr=0, data=0.
- Load extraction, rdata=0x80FF7F01, ack after 3 wait cycles: LB off 3 -> 0xFFFFFF80; LBU off 1 -> 0x0000007F; LH off 2 -> 0xFFFF80FF; LHU off 0 -> 0x00007F01; LW -> 0x80FF7F01; write one cycle after ack, addr=0x..0 word-aligned.
- Misaligned LW at 0x1002 and funct3=011 -> no req, fault pulse next cycle, no write, ready stays 1.
- Ack and err together in first req cycle -> fault pulse, no write; TIMEOUT_CYCLES=4 with no response -> req high exactly 4 cycles, then fault pulse.
- Alternating load (ack immediate)/ALU ops -> ready low exactly one cycle per load, writes in issue order, no lost or duplicated writes.
